// File: rtl/multihot_index_encoder_if.sv
// ---------------------------------------------------------------------------
// multihot_index_encoder_if
// Handshake bundle for the multi-hot to index encoder.
//   in_vec/in_valid/in_ready       : vector input handshake (producer -> encoder)
//   idx_out/idx_valid/idx_ready    : index output handshake (encoder -> consumer)
//   idx_last                       : marks the final index of the current vector
//   done                           : one-cycle pulse after a vector fully drains
//   busy                           : a vector is held or being drained
// Modports: slave = encoder side, master = producer/consumer side.
// ---------------------------------------------------------------------------
interface multihot_index_encoder_if;
   localparam int unsigned VEC_W = 32;
   localparam int unsigned IDX_W = 5;

   logic [VEC_W-1:0] in_vec;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] idx_out;
   logic             idx_valid;
   logic             idx_ready;
   logic             idx_last;
   logic             done;
   logic             busy;

   modport slave (
      input  in_vec, in_valid, idx_ready,
      output in_ready, idx_out, idx_valid, idx_last, done, busy
   );

   modport master (
      output in_vec, in_valid, idx_ready,
      input  in_ready, idx_out, idx_valid, idx_last, done, busy
   );
endinterface

// File: rtl/multihot_index_encoder.sv
// ---------------------------------------------------------------------------
// multihot_index_encoder
// Sequential 32-to-5 encoder: accepts a multi-hot vector and emits the index
// of every set bit, one per idx handshake. LSB first by default; defining
// ENC_MSB_FIRST_EN switches the priority encode to highest-set-bit first.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : multihot_index_encoder_if.slave (vector in, index out, done, busy)
// ---------------------------------------------------------------------------
module multihot_index_encoder (
   input logic                      clock,
   input logic                      reset,
   multihot_index_encoder_if.slave  bus
);
   localparam int unsigned VEC_W = 32;
   localparam int unsigned IDX_W = 5;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [VEC_W-1:0] pending_q, pending_d;
   logic             done_q, done_d;

   logic [IDX_W-1:0] enc_idx;
   logic             enc_last;

   logic             in_ready_c;
   logic             idx_valid_c;
   logic [IDX_W-1:0] idx_out_c;
   logic             idx_last_c;
   logic             busy_c;

   // Priority encode of the pending register only; stable while held
   always_comb begin
      enc_idx = '0;
`ifdef ENC_MSB_FIRST_EN
      for (int i = 0; i < int'(VEC_W); i++) begin
         if (pending_q[i]) enc_idx = IDX_W'(i);
      end
`else
      for (int i = int'(VEC_W) - 1; i >= 0; i--) begin
         if (pending_q[i]) enc_idx = IDX_W'(i);
      end
`endif
   end

   // Exactly one bit remaining: clearing the lowest set bit leaves zero
   assign enc_last = (pending_q != '0) &&
                     ((pending_q & (pending_q - VEC_W'(1))) == '0);

   // Next-state and handshake outputs
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      done_d      = 1'b0;
      in_ready_c  = 1'b0;
      idx_valid_c = 1'b0;
      idx_out_c   = '0;
      idx_last_c  = 1'b0;
      busy_c      = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               pending_d = bus.in_vec;
               if (bus.in_vec != '0) state_d = SCAN;
               else                  done_d  = 1'b1;
            end
         end
         SCAN: begin
            busy_c      = 1'b1;
            idx_valid_c = 1'b1;
            idx_out_c   = enc_idx;
            idx_last_c  = enc_last;
            if (bus.idx_ready) begin
               pending_d[enc_idx] = 1'b0;
               if (enc_last) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset blanks every handshake output in the same cycle
      if (reset) begin
         in_ready_c  = 1'b0;
         idx_valid_c = 1'b0;
         idx_out_c   = '0;
         idx_last_c  = 1'b0;
         busy_c      = 1'b0;
      end
   end

   // State, data and done registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         done_q    <= done_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.idx_valid = idx_valid_c;
   assign bus.idx_out   = idx_out_c;
   assign bus.idx_last  = idx_last_c;
   assign bus.busy      = busy_c;
   assign bus.done      = done_q;
endmodule
